// File: rtl/mips_single_cycle.sv
// mips_single_cycle
// -----------------
// Single-cycle 32-bit MIPS subset core. Each rising clk edge fetches,
// decodes, executes and retires one instruction. Program and data share
// one word-addressed memory. The memory is loaded from outside by
// hierarchical writes, so the core has no external bus.
//
// Supported instructions:
//   R-type: add, sub, and, or, slt
//   I-type: addi, lw, sw, beq
//   J-type: j
// Any other opcode or R-type funct retires as a no-op (pc advances by 4).
//
// Ports:
//   clk   - single clock; all state updates on the rising edge
//   reset - synchronous, active-high. It clears pc and reg_file, but not
//           memory. It takes priority over the instruction executing in
//           that cycle.
//
// There are no handshakes: every instruction completes in exactly one
// cycle. There is no FSM; the only sequential state is pc, reg_file
// and memory.

module mips_single_cycle #(
  parameter int MEM_WORDS = 1024
) (
  input logic clk,
  input logic reset
);

  // Word-index width. With the default size the index is byte address
  // bits [11:2]; higher address bits are dropped, so large addresses alias.
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Architectural state
  logic [31:0] memory   [0:MEM_WORDS-1];
  logic [31:0] reg_file [0:31];
  logic [31:0] pc;

  // Datapath
  logic [31:0] instruction;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] sign_extend;
  logic [31:0] alu_input_2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_read_data;
  logic [31:0] write_data;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] pc_next;
  logic [4:0]  write_reg;
  logic [AW-1:0] fetch_index;
  logic [AW-1:0] data_index;

  // Control signals
  logic reg_write;
  logic reg_dst;
  logic alu_src;
  logic mem_write;
  logic mem_to_reg;
  logic branch;
  logic jump;

  // Shamt (instruction bits [10:6]) is not used by any supported
  // instruction.
  logic unused_shamt;
  assign unused_shamt = &{1'b0, instruction[10:6]};

  // Fetch and decode. pc[1:0] is ignored.
  assign fetch_index = pc[AW+1:2];
  assign instruction = memory[fetch_index];

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];
  assign imm    = instruction[15:0];
  assign target = instruction[25:0];

  assign read_data_1 = reg_file[rs];
  assign read_data_2 = reg_file[rt];
  assign sign_extend = {{16{imm[15]}}, imm};

  // Main decoder. Every output gets a default, so an unsupported opcode
  // or funct writes nothing and falls through to pc+4.
  always_comb begin
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_control = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = ALU_ADD; end
          FN_SUB: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = ALU_SUB; end
          FN_AND: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = ALU_AND; end
          FN_OR:  begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = ALU_OR;  end
          FN_SLT: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_BEQ: begin
        branch      = 1'b1;
        alu_control = ALU_SUB;
      end
      OP_J: begin
        jump = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU. Arithmetic is 32-bit wraparound with no overflow trap.
  assign alu_input_2 = alu_src ? sign_extend : read_data_2;

  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      ALU_ADD: alu_result = read_data_1 + alu_input_2;
      ALU_SUB: alu_result = read_data_1 - alu_input_2;
      ALU_AND: alu_result = read_data_1 & alu_input_2;
      ALU_OR:  alu_result = read_data_1 | alu_input_2;
      ALU_SLT: alu_result = ($signed(read_data_1) < $signed(alu_input_2)) ? 32'h1 : 32'h0;
      default: alu_result = 32'h0;
    endcase
  end

  assign zero = (alu_result == 32'h0);

  // Data memory read. The low two address bits are ignored.
  assign data_index    = alu_result[AW+1:2];
  assign mem_read_data = memory[data_index];
  assign write_data    = mem_to_reg ? mem_read_data : alu_result;
  assign write_reg     = reg_dst ? rd : rt;

  // Next pc
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {sign_extend[29:0], 2'b00};

  always_comb begin
    if (jump) begin
      pc_next = {pc_plus4[31:28], target, 2'b00};
    end else if (branch && zero) begin
      pc_next = branch_target;
    end else begin
      pc_next = pc_plus4;
    end
  end

  // pc and register file. Writes to register 0 are dropped, so
  // reg_file[0] always reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 32'h0;
      for (int i = 0; i < 32; i++) begin
        reg_file[i] <= 32'h0;
      end
    end else begin
      pc <= pc_next;
      if (reg_write && (write_reg != 5'd0)) begin
        reg_file[write_reg] <= write_data;
      end
    end
  end

  // Memory is never cleared. A store is suppressed in a reset cycle.
  // A store may overwrite instruction words; later fetches see the new
  // value.
  always_ff @(posedge clk) begin
    if (!reset && mem_write) begin
      memory[data_index] <= read_data_2;
    end
  end

endmodule

// File: tb/tb_mips_single_cycle.sv
// tb_mips_single_cycle
// --------------------
// Directed bench for mips_single_cycle. Programs are placed in the core's
// memory by hierarchical writes. Architectural state is then checked
// after each clock edge against hand-computed values.

module tb_mips_single_cycle;

  logic clk;
  logic reset;

  int checks;
  int errors;

  logic [31:0] exp_q [$];

  mips_single_cycle #(.MEM_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Samples 1 ns after the rising edge, well away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clear_memory();
    for (int i = 0; i < 1024; i++) begin
      dut.memory[i] = 32'h0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;

    // Self-modifying arithmetic / load-store / branch / jump program
    clear_memory();
    dut.memory[0] = 32'h20090005; // addi $t1,$0,5
    dut.memory[1] = 32'h200A000A; // addi $t2,$0,10
    dut.memory[2] = 32'h012A4020; // add  $t0,$t1,$t2
    dut.memory[3] = 32'h012A4022; // sub  $t0,$t1,$t2
    dut.memory[4] = 32'h012A4024; // and  $t0,$t1,$t2
    dut.memory[5] = 32'h012A4025; // or   $t0,$t1,$t2
    dut.memory[6] = 32'hAC0A0000; // sw   $t2,0($0)
    dut.memory[7] = 32'h8C0B0000; // lw   $t3,0($0)
    dut.memory[8] = 32'h11690002; // beq  $t3,$t1,+2 (not taken)
    dut.memory[9] = 32'h08000000; // j    0

    // Hold reset over the edge at 5 ns; release at 10 ns.
    @(posedge clk);
    #5;
    reset = 1'b0;
    check("reset_pc", dut.pc, 32'h0);
    check("reset_t1", dut.reg_file[9], 32'h0);
    check("reset_t0", dut.reg_file[8], 32'h0);
    check("fetch_first", dut.instruction, 32'h20090005);

    // Expected pc after each of the 20 edges: 4,8,...,36, then 0 after j.
    for (int n = 1; n <= 20; n++) begin
      exp_q.push_back(((n % 10) == 0) ? 32'h0 : 32'((n % 10) * 4));
    end

    for (int n = 1; n <= 20; n++) begin
      logic [31:0] exp_pc;
      step();
      exp_pc = exp_q.pop_front();
      check($sformatf("loop_pc_edge%0d", n), dut.pc, exp_pc);
      case (n)
        1:  check("addi_t1", dut.reg_file[9], 32'h00000005);
        2:  check("addi_t2", dut.reg_file[10], 32'h0000000A);
        3:  check("add_t0", dut.reg_file[8], 32'h0000000F);
        4:  check("sub_t0", dut.reg_file[8], 32'hFFFFFFFB);
        5:  check("and_t0", dut.reg_file[8], 32'h00000000);
        6:  check("or_t0", dut.reg_file[8], 32'h0000000F);
        7:  check("sw_mem0", dut.memory[0], 32'h0000000A);
        8:  check("lw_t3", dut.reg_file[11], 32'h0000000A);
        10: check("second_pass_fetch", dut.instruction, 32'h0000000A);
        11: begin
          // The overwritten word at pc 0 retires as a no-op.
          check("noop_t0", dut.reg_file[8], 32'h0000000F);
          check("noop_t1", dut.reg_file[9], 32'h00000005);
          check("noop_mem0", dut.memory[0], 32'h0000000A);
        end
        default: ;
      endcase
    end

    check("end_t1", dut.reg_file[9], 32'h00000005);
    check("end_t2", dut.reg_file[10], 32'h0000000A);
    check("end_t0", dut.reg_file[8], 32'h0000000F);
    check("end_t3", dut.reg_file[11], 32'h0000000A);
    check("end_mem0", dut.memory[0], 32'h0000000A);

    // Reset mid-run: pc and every register clear; memory is kept.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_pc", dut.pc, 32'h0);
    for (int r = 0; r < 32; r++) begin
      check($sformatf("midreset_r%0d", r), dut.reg_file[r], 32'h0);
    end
    check("midreset_mem0_kept", dut.memory[0], 32'h0000000A);

    // $zero, taken branch, slt with a negative operand, aliased load
    clear_memory();
    dut.memory[0] = 32'h20000007; // addi $0,$0,7
    dut.memory[1] = 32'h20090005; // addi $t1,$0,5
    dut.memory[2] = 32'h200B0005; // addi $t3,$0,5
    dut.memory[3] = 32'h11690002; // beq  $t3,$t1,+2 (taken -> 24)
    dut.memory[4] = 32'h20080063; // addi $t0,$0,99 (skipped)
    dut.memory[5] = 32'h20080063; // addi $t0,$0,99 (skipped)
    dut.memory[6] = 32'h200AFFFF; // addi $t2,$0,-1
    dut.memory[7] = 32'h0149402A; // slt  $t0,$t2,$t1
    dut.memory[8] = 32'h8C0B1002; // lw   $t3,0x1002($0) -> aliases word 0
    dut.memory[9] = 32'h08000000; // j    0

    step();
    check("zero_reg_kept", dut.reg_file[0], 32'h0);
    check("zero_pc", dut.pc, 32'h4);
    step();
    check("b_t1", dut.reg_file[9], 32'h5);
    step();
    check("b_t3", dut.reg_file[11], 32'h5);
    check("beq_alu_control", {28'h0, dut.alu_control}, 32'h6);
    check("beq_zero", {31'h0, dut.zero}, 32'h1);
    step();
    check("beq_taken_pc", dut.pc, 32'd24);
    step();
    check("addi_neg_t2", dut.reg_file[10], 32'hFFFFFFFF);
    check("skip_t0", dut.reg_file[8], 32'h0);
    step();
    check("slt_t0", dut.reg_file[8], 32'h00000001);
    check("slt_pc", dut.pc, 32'd32);
    step();
    check("lw_alias_t3", dut.reg_file[11], 32'h20000007);
    step();
    check("j_pc", dut.pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
